// File: rtl/div_issue_ctrl_pkg.sv
// rtl/div_issue_ctrl_pkg.sv - shared state encoding, widths and constants for div_issue_ctrl
package div_issue_ctrl_pkg;

  localparam int DATA_W = 32;

  // Quotient reported for a zero divisor when the bypass path is built in
  localparam logic [DATA_W-1:0] DIV0_Q = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } div_state_e;

  function automatic logic [DATA_W-1:0] cond_neg(input logic neg, input logic [DATA_W-1:0] v);
    return neg ? (~v + DATA_W'(1)) : v;
  endfunction

endpackage

// File: rtl/div_sign_fix.sv
// rtl/div_sign_fix.sv - applies result signs to divider magnitude quotient/remainder
module div_sign_fix
  import div_issue_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] mag_q,
  input  logic [DATA_W-1:0] mag_r,
  input  logic              sign_q,
  input  logic              sign_r,
  output logic [DATA_W-1:0] q,
  output logic [DATA_W-1:0] r
);

  assign q = cond_neg(sign_q, mag_q);
  assign r = cond_neg(sign_r, mag_r);

endmodule

// File: rtl/div_issue_ctrl.sv
// rtl/div_issue_ctrl.sv - issue/complete controller around the iterative divider
// Optional zero-divisor short cut built in with DIV_ZERO_BYPASS_EN.
module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
#(
  parameter int TAG_W       = 5,
  parameter int TIMEOUT_CYC = 40
) (
  input  logic              div_clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_signed,
  input  logic [DATA_W-1:0] req_x,
  input  logic [DATA_W-1:0] req_y,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              div,
  output logic              div_signed,
  output logic [DATA_W-1:0] div_x,
  output logic [DATA_W-1:0] div_y,
  input  logic [DATA_W-1:0] div_s,
  input  logic [DATA_W-1:0] div_r,
  input  logic              div_complete,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_q,
  output logic [DATA_W-1:0] resp_r,
  output logic [TAG_W-1:0]  resp_tag,
  output logic              resp_div0,
  output logic              resp_err
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  div_state_e        state;
  div_state_e        state_nxt;
  logic [CNT_W-1:0]  tmo_cnt;
  logic              sign_q;
  logic              sign_r;
  logic [TAG_W-1:0]  tag_q;
  logic [DATA_W-1:0] fix_q;
  logic [DATA_W-1:0] fix_r;
  logic              req_fire;
  logic              div0_req;
  logic              tmo_hit;
  logic              x_neg;
  logic              y_neg;

  assign req_fire   = (state == ST_IDLE) && req_valid;
  assign tmo_hit    = (tmo_cnt == CNT_LAST);
  assign x_neg      = req_signed & req_x[DATA_W-1];
  assign y_neg      = req_signed & req_y[DATA_W-1];
  assign div_signed = 1'b0;

`ifdef DIV_ZERO_BYPASS_EN
  assign div0_req = (req_y == '0);
`else
  assign div0_req = 1'b0;
`endif

  div_sign_fix u_sign_fix (
    .mag_q  (div_s),
    .mag_r  (div_r),
    .sign_q (sign_q),
    .sign_r (sign_r),
    .q      (fix_q),
    .r      (fix_r)
  );

  always_ff @(posedge div_clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (req_valid) state_nxt = div0_req ? ST_DONE : ST_ISSUE;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  if (div_complete || tmo_hit) state_nxt = ST_DONE;
      ST_DONE:  if (resp_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Handshake/strobe outputs follow the next state so they are registered yet aligned with it
  always_ff @(posedge div_clk or posedge reset) begin
    if (reset) begin
      req_ready  <= 1'b1;
      div        <= 1'b0;
      resp_valid <= 1'b0;
      div_x      <= '0;
      div_y      <= '0;
      sign_q     <= 1'b0;
      sign_r     <= 1'b0;
      tag_q      <= '0;
      tmo_cnt    <= '0;
      resp_q     <= '0;
      resp_r     <= '0;
      resp_tag   <= '0;
      resp_err   <= 1'b0;
    end else begin
      req_ready  <= (state_nxt == ST_IDLE);
      div        <= (state_nxt == ST_ISSUE);
      resp_valid <= (state_nxt == ST_DONE);
      case (state)
        ST_IDLE: begin
          if (req_fire) begin
            sign_q <= req_signed & (req_x[DATA_W-1] ^ req_y[DATA_W-1]);
            sign_r <= x_neg;
            tag_q  <= req_tag;
            if (!div0_req) begin
              div_x <= cond_neg(x_neg, req_x);
              div_y <= cond_neg(y_neg, req_y);
            end else begin
              resp_q   <= DIV0_Q;
              resp_r   <= req_x;
              resp_tag <= req_tag;
              resp_err <= 1'b0;
            end
          end
        end
        ST_ISSUE: tmo_cnt <= '0;
        ST_WAIT: begin
          if (div_complete) begin
            resp_q   <= fix_q;
            resp_r   <= fix_r;
            resp_tag <= tag_q;
            resp_err <= 1'b0;
          end else if (tmo_hit) begin
            resp_q   <= '0;
            resp_r   <= '0;
            resp_tag <= tag_q;
            resp_err <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DIV_ZERO_BYPASS_EN
  always_ff @(posedge div_clk or posedge reset) begin
    if (reset) begin
      resp_div0 <= 1'b0;
    end else if (req_fire) begin
      resp_div0 <= div0_req;
    end
  end
`else
  assign resp_div0 = 1'b0;
`endif

endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb/tb_div_issue_ctrl.sv - directed scoreboard bench for div_issue_ctrl with a stub divider
module tb_div_issue_ctrl;

  localparam int TAG_W       = 5;
  localparam int TIMEOUT_CYC = 40;
  localparam int STUB_DLY    = 35;
`ifdef DIV_ZERO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic              div_clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_signed = 1'b0;
  logic [31:0]       req_x = '0;
  logic [31:0]       req_y = '0;
  logic [TAG_W-1:0]  req_tag = '0;
  logic              div;
  logic              div_signed;
  logic [31:0]       div_x;
  logic [31:0]       div_y;
  logic [31:0]       div_s = '0;
  logic [31:0]       div_r = '0;
  logic              div_complete = 1'b0;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic [31:0]       resp_q;
  logic [31:0]       resp_r;
  logic [TAG_W-1:0]  resp_tag;
  logic              resp_div0;
  logic              resp_err;

  always #5 div_clk = ~div_clk;

  div_issue_ctrl #(.TAG_W(TAG_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .div_clk      (div_clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_signed   (req_signed),
    .req_x        (req_x),
    .req_y        (req_y),
    .req_tag      (req_tag),
    .div          (div),
    .div_signed   (div_signed),
    .div_x        (div_x),
    .div_y        (div_y),
    .div_s        (div_s),
    .div_r        (div_r),
    .div_complete (div_complete),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_q       (resp_q),
    .resp_r       (resp_r),
    .resp_tag     (resp_tag),
    .resp_div0    (resp_div0),
    .resp_err     (resp_err)
  );

  typedef struct {
    logic [31:0]      q;
    logic [31:0]      r;
    logic [TAG_W-1:0] tag;
    logic             err;
    logic             div0;
    int               lat;
    int               pulses;
    logic [31:0]      dx;
    logic [31:0]      dy;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Stub divider: strobes STUB_DLY cycles after the pulse; extra strobe cycles carry junk
  logic        stub_en = 1'b1;
  int          strobe_len = 1;
  int          dly_cnt = 0;
  int          hold = 0;
  int          pulse_cnt = 0;
  logic [31:0] pend_s = '0;
  logic [31:0] pend_r = '0;
  logic [31:0] seen_x = '0;
  logic [31:0] seen_y = '0;
  logic        seen_signed = 1'b0;

  always @(negedge div_clk) begin
    if (div) begin
      pulse_cnt++;
      seen_x = div_x;
      seen_y = div_y;
      seen_signed = div_signed;
      if (stub_en) begin
        pend_s = (div_y == 0) ? 32'hFFFF_FFFF : div_x / div_y;
        pend_r = (div_y == 0) ? div_x : div_x % div_y;
        dly_cnt = STUB_DLY;
      end
    end else if (dly_cnt > 0) begin
      dly_cnt--;
      if (dly_cnt == 0) begin
        div_complete = 1'b1;
        div_s = pend_s;
        div_r = pend_r;
        hold = strobe_len - 1;
      end
    end else if (hold > 0) begin
      hold--;
      div_s = ~div_s;
      div_r = ~div_r;
    end else begin
      div_complete = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic s, input logic [31:0] x, input logic [31:0] y,
                                 input logic [TAG_W-1:0] tag, input logic tmo);
    exp_t   e;
    longint sx, sy, ax, ay, q64, r64;
    sx = s ? longint'($signed(x)) : longint'({32'b0, x});
    sy = s ? longint'($signed(y)) : longint'({32'b0, y});
    ax = (sx < 0) ? -sx : sx;
    ay = (sy < 0) ? -sy : sy;
    e.dx = ax[31:0];
    e.dy = ay[31:0];
    e.tag = tag;
    e.err = 1'b0;
    e.div0 = 1'b0;
    e.pulses = 1;
    e.lat = STUB_DLY + 1;
    if (tmo) begin
      e.q = '0;
      e.r = '0;
      e.err = 1'b1;
      e.lat = TIMEOUT_CYC + 1;
    end else if (y == 0) begin
      e.q = 32'hFFFF_FFFF;
      e.r = x;
      if (BYPASS) begin
        e.div0 = 1'b1;
        e.pulses = 0;
        e.lat = 0;
      end
    end else begin
      q64 = sx / sy;
      r64 = sx % sy;
      e.q = q64[31:0];
      e.r = r64[31:0];
    end
    return e;
  endfunction

  task automatic run_req(input string name, input logic s, input logic [31:0] x, input logic [31:0] y,
                         input logic [TAG_W-1:0] tag, input int hold_cyc, input logic tmo);
    exp_t e;
    int   base;
    int   lat;
    sb.push_back(model(s, x, y, tag, tmo));
    base = pulse_cnt;
    @(negedge div_clk);
    req_valid = 1'b1;
    req_signed = s;
    req_x = x;
    req_y = y;
    req_tag = tag;
    @(posedge div_clk);
    #1;
    req_valid = 1'b0;
    check({name, ".req_ready_busy"}, req_ready, 1'b0);
    check({name, ".div_t1"}, div, (sb[$].pulses == 1));
    lat = 0;
    while (!resp_valid && lat < 100) begin
      @(posedge div_clk);
      #1;
      lat++;
      if (lat == 1) check({name, ".div_t2"}, div, 1'b0);
    end
    e = sb.pop_front();
    check({name, ".latency"}, lat, e.lat);
    check({name, ".pulses"}, pulse_cnt - base, e.pulses);
    if (e.pulses == 1) begin
      check({name, ".div_x"}, seen_x, e.dx);
      check({name, ".div_y"}, seen_y, e.dy);
      check({name, ".div_signed"}, seen_signed, 1'b0);
    end
    check({name, ".resp_q"}, resp_q, e.q);
    check({name, ".resp_r"}, resp_r, e.r);
    check({name, ".resp_tag"}, resp_tag, e.tag);
    check({name, ".resp_err"}, resp_err, e.err);
    check({name, ".resp_div0"}, resp_div0, e.div0);
    for (int i = 0; i < hold_cyc; i++) begin
      @(posedge div_clk);
      #1;
      check({name, ".hold_valid"}, resp_valid, 1'b1);
      check({name, ".hold_ready"}, req_ready, 1'b0);
      check({name, ".hold_q"}, resp_q, e.q);
      check({name, ".hold_r"}, resp_r, e.r);
    end
    resp_ready = 1'b1;
    @(posedge div_clk);
    #1;
    resp_ready = 1'b0;
    check({name, ".req_ready_after"}, req_ready, 1'b1);
    check({name, ".resp_valid_after"}, resp_valid, 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge div_clk);
    #1;
    check("rst.req_ready", req_ready, 1'b1);
    check("rst.div", div, 1'b0);
    check("rst.resp_valid", resp_valid, 1'b0);
    check("rst.div_x", div_x, 32'h0);
    check("rst.resp_q", resp_q, 32'h0);
    check("rst.resp_r", resp_r, 32'h0);
    check("rst.resp_tag", resp_tag, 5'h0);
    check("rst.resp_err", resp_err, 1'b0);
    check("rst.resp_div0", resp_div0, 1'b0);
    @(negedge div_clk);
    reset = 1'b0;

    run_req("unsigned", 1'b0, 32'd100, 32'd7, 5'd3, 0, 1'b0);
    run_req("signed", 1'b1, 32'hFFFF_FFF9, 32'd2, 5'd5, 0, 1'b0);
    run_req("overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 0, 1'b0);
    run_req("pos_neg", 1'b1, 32'd100, 32'hFFFF_FFF9, 5'd10, 0, 1'b0);
    run_req("neg_neg", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 5'd11, 0, 1'b0);
    run_req("u_big", 1'b0, 32'hFFFF_FFFF, 32'd16, 5'd12, 0, 1'b0);
    run_req("u_small", 1'b0, 32'd7, 32'd100, 5'd13, 0, 1'b0);
    run_req("div0", 1'b0, 32'd5, 32'd0, 5'd14, 0, 1'b0);
    run_req("backpressure", 1'b0, 32'd1000, 32'd33, 5'd21, 10, 1'b0);

    strobe_len = 2;
    run_req("dbl_strobe", 1'b1, 32'hFFFF_FFCE, 32'd6, 5'd22, 0, 1'b0);
    strobe_len = 1;

    stub_en = 1'b0;
    run_req("timeout", 1'b0, 32'd9, 32'd3, 5'd30, 0, 1'b1);

    @(negedge div_clk);
    req_valid = 1'b1;
    req_signed = 1'b0;
    req_x = 32'd77;
    req_y = 32'd5;
    req_tag = 5'd31;
    @(posedge div_clk);
    #1;
    req_valid = 1'b0;
    repeat (5) @(posedge div_clk);
    #3;
    reset = 1'b1;
    #1;
    check("midrst.resp_valid", resp_valid, 1'b0);
    check("midrst.div", div, 1'b0);
    check("midrst.req_ready", req_ready, 1'b1);
    @(negedge div_clk);
    reset = 1'b0;
    stub_en = 1'b1;

    run_req("post_reset", 1'b1, 32'hFFFF_FF9C, 32'd7, 5'd7, 0, 1'b0);
    check("sb.empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_issue_ctrl.md
# div_issue_ctrl

Request-side controller that sits directly upstream and downstream of the iterative 32-bit divider in the CPU execute stage. It accepts a divide request from the EX pipeline with a valid/ready handshake and converts signed operands to magnitudes. It issues a one-cycle start pulse to the divider, waits for its completion strobe, applies sign correction to the quotient and remainder, and holds the result for writeback with a valid/ready handshake.

## Interface
- TAG_W, 5: width of the destination-register tag carried with each request
- TIMEOUT_CYC, 40: cycles allowed in WAIT before the request is aborted with an error
- div_clk  in  1  block clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request; reset 1
- req_signed  in  1  1 = signed divide, 0 = unsigned
- req_x / req_y  in  32  dividend / divisor
- req_tag  in  TAG_W  opaque tag returned with the result
- div  out  1  start pulse to divider; exactly one cycle per issue; reset 0
- div_signed  out  1  always 0, because magnitudes are issued; reset 0
- div_x / div_y  out  32  dividend / divisor magnitudes; reset 0
- div_s / div_r  in  32  divider magnitude quotient / remainder
- div_complete  in  1  divider completion strobe
- resp_valid  out  1  result held; reset 0
- resp_ready  in  1  writeback accepts result
- resp_q / resp_r  out  32  signed-corrected quotient / remainder; reset 0
- resp_tag  out  TAG_W  tag of the request; reset 0
- resp_div0  out  1  divisor was zero; reset 0
- resp_err  out  1  divider timed out; reset 0

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. Reset state is IDLE.
- IDLE: req_ready=1. On req_valid, latch the following and go to ISSUE:
  - sign_q = req_signed & (x[31]^y[31])
  - sign_r = req_signed & x[31]
  - |x| and |y|, where |v| = (req_signed & v[31]) ? -v : v, in 32-bit two's-complement
  - tag and raw x
- ISSUE: div=1 for this cycle only, with div_x/div_y stable. Clear the timeout counter. Go to WAIT.
- WAIT: div=0. The timeout counter increments each cycle.
  - On div_complete=1: capture q = sign_q ? -div_s : div_s and r = sign_r ? -div_r : div_r. Set resp_err=0 and go to DONE.
  - Completion is captured on the first cycle the strobe is seen; any further strobe cycles are ignored.
  - If the counter reaches TIMEOUT_CYC with no strobe: q=0, r=0, resp_err=1, go to DONE.
- DONE: resp_valid=1 and all resp_* are held stable. On resp_ready, go to IDLE.
- req_ready is 0 in ISSUE, WAIT and DONE, so a response and a new request are never accepted in the same cycle.
- Overflow case: signed 0x80000000 / 0xFFFFFFFF gives q=0x80000000, r=0 (wraps, no flag).
- Reset mid-operation: FSM returns to IDLE asynchronously, div drops to 0, and the in-flight result is discarded. The parent also holds the divider in reset, because its resetn is synchronous.

## Timing
- Request accepted on edge t. div is high during cycle t+1.
- resp_valid rises on the edge after div_complete is first sampled high. The divider's nominal strobe arrives 35 cycles after the div pulse.
- Divide-by-zero bypass (see Configuration): resp_valid is high at t+1; the divider is never started.
- Minimum gap between back-to-back accepts is response latency + 1 cycle. req_ready rises the cycle after the resp_valid & resp_ready handshake.
- All outputs are registered. No combinational path from req_* to div_* or from div_* to resp_*.

## Configuration
- DIV_ZERO_BYPASS_EN defined:
  - In IDLE, when req_y==0, skip ISSUE/WAIT and go straight to DONE.
  - Result: q=0xFFFFFFFF, r=raw x, resp_div0=1. The divider is never started.
- DIV_ZERO_BYPASS_EN undefined:
  - A zero divisor is issued like any other request, and the result is whatever the divider returns after sign correction.
  - resp_div0 is tied to 0.

## Structure
- Shared package: FSM state encoding (2-bit), the 32-bit absolute-value/negate constant widths, and the divide-by-zero quotient constant 0xFFFFFFFF.
- One sub-module: div_sign_fix. It is combinational and takes magnitude q/r plus sign_q/sign_r and produces signed q/r. It is shared by capture and verification.
- The divider is instantiated by the parent; this block only connects to its ports.

## Test plan
- Unsigned: x=100, y=7 -> resp_q=14, resp_r=2, resp_err=0. Exactly one div pulse with div_x=100, div_y=7.
- Signed: x=-7 (0xFFFFFFF9), y=2 -> div_x=7, div_y=2; resp_q=0xFFFFFFFD (-3), resp_r=0xFFFFFFFF (-1).
- Signed overflow: x=0x80000000, y=0xFFFFFFFF -> resp_q=0x80000000, resp_r=0.
- Divide by zero with DIV_ZERO_BYPASS_EN: x=5, y=0 -> resp_valid at t+1, q=0xFFFFFFFF, r=5, resp_div0=1, no div pulse.
- Backpressure: hold resp_ready=0 for 10 cycles -> resp_* stable, req_ready=0 throughout. Release -> req_ready=1 next cycle.
- Timeout and reset: stub divider never strobes -> after 40 WAIT cycles resp_err=1, q=r=0. A separate run asserts reset mid-WAIT -> resp_valid=0, div=0, req_ready=1 immediately.
